// File: rtl/cory_arbn_if.sv
`default_nettype none
// ============================================================================
// Module   : cory_arbn_if
// Purpose  : Bundles the M request channels and the merged output channel of
//            the cory_arbn arbiter.
// Ports    : i_a_v/i_a_d/i_a_l  request valid, data (port k at [k*N +: N]),
//                                last-beat flag
//            o_a_r               per-port ready
//            o_z_v/o_z_d/o_z_s/o_z_l  output valid, data, source index, last
//            i_z_r               downstream ready
//            o_wdog              sticky starvation flags (CORY_ARBN_WDOG_EN)
// Modports : slave  - arbiter side; master - requesters/downstream side
// Macro    : CORY_ARBN_WDOG_EN adds o_wdog
// Revision : 1.0 - initial release
// ============================================================================
interface cory_arbn_if #(
   parameter int M = 4,
   parameter int N = 8
);
   localparam int S = (M > 1) ? $clog2(M) : 1;

   logic [M-1:0]   i_a_v;
   logic [M*N-1:0] i_a_d;
   logic [M-1:0]   i_a_l;
   logic [M-1:0]   o_a_r;
   logic           o_z_v;
   logic [N-1:0]   o_z_d;
   logic [S-1:0]   o_z_s;
   logic           o_z_l;
   logic           i_z_r;
`ifdef CORY_ARBN_WDOG_EN
   logic [M-1:0]   o_wdog;
`endif

   modport slave (
      input  i_a_v, i_a_d, i_a_l, i_z_r,
      output o_a_r, o_z_v, o_z_d, o_z_s, o_z_l
`ifdef CORY_ARBN_WDOG_EN
      , output o_wdog
`endif
   );

   modport master (
      output i_a_v, i_a_d, i_a_l, i_z_r,
      input  o_a_r, o_z_v, o_z_d, o_z_s, o_z_l
`ifdef CORY_ARBN_WDOG_EN
      , input o_wdog
`endif
   );
endinterface
`default_nettype wire

// File: rtl/cory_arbn.sv
`default_nettype none
// ============================================================================
// Module   : cory_arbn
// Purpose  : M-port valid/ready arbiter with packet locking. Merges M N-bit
//            request channels into one output channel tagged with the source
//            port index. Round-robin or fixed priority; optional 2-entry
//            registered skid output that removes the i_z_r -> o_a_r path.
// Ports    : clk    clock, rising edge
//            reset  asynchronous active-high reset
//            arb    cory_arbn_if.slave (request channels, output channel)
// Params   : M ports, N data bits, ROUND (1 rr / 0 fixed), Q (0 comb /
//            1 skid), WDOG starvation threshold
// Macro    : CORY_ARBN_WDOG_EN enables per-port starvation watchdog (o_wdog)
// Revision : 1.0 - initial release
// ============================================================================
module cory_arbn #(
   parameter int M     = 4,
   parameter int N     = 8,
   parameter int ROUND = 1,
   parameter int Q     = 1,
   parameter int WDOG  = 255
) (
   input  wire logic     clk,
   input  wire logic     reset,
   cory_arbn_if.slave    arb
);
   localparam int S = (M > 1) ? $clog2(M) : 1;

   logic [S-1:0] r_ptr;
   logic         r_lock;
   logic [S-1:0] r_lport;

   logic [M-1:0] w_grant;
   logic [S-1:0] w_gidx;
   logic         w_gsel;     // a port is selected (always true while locked)
   logic [S:0]   w_sum;      // ptr + offset before the modulo-M fold
   logic         w_gv;
   logic [M-1:0] w_rdy;
   logic         w_acc;
   logic [N-1:0] w_in_d;
   logic         w_in_l;

   // Grant selection. While a packet is open the grant stays on the locked
   // port even if it is momentarily not valid, so no other port can slip in.
   always_comb begin
      w_grant = '0;
      w_gidx  = '0;
      w_gsel  = 1'b0;
      w_sum   = '0;
      if (r_lock) begin
         w_gidx = r_lport;
         w_gsel = 1'b1;
      end else if (ROUND != 0) begin
         for (int i = 0; i < M; i++) begin
            w_sum = {1'b0, r_ptr} + (S+1)'(i);
            if (w_sum >= (S+1)'(M))
               w_sum = w_sum - (S+1)'(M);
            if (!w_gsel && arb.i_a_v[w_sum[S-1:0]]) begin
               w_gsel = 1'b1;
               w_gidx = w_sum[S-1:0];
            end
         end
      end else begin
         for (int i = 0; i < M; i++) begin
            if (!w_gsel && arb.i_a_v[i]) begin
               w_gsel = 1'b1;
               w_gidx = S'(i);
            end
         end
      end
      if (w_gsel)
         w_grant[w_gidx] = 1'b1;
   end

   assign w_gv   = w_gsel & arb.i_a_v[w_gidx];
   assign w_in_d = arb.i_a_d[int'(w_gidx)*N +: N];
   assign w_in_l = arb.i_a_l[w_gidx];
   assign w_acc  = |(arb.i_a_v & w_rdy);
   assign arb.o_a_r = w_rdy;

   // Packet lock and round-robin pointer. A last beat always releases the
   // lock and moves the start point just past the port that finished.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr   <= '0;
         r_lock  <= 1'b0;
         r_lport <= '0;
      end else if (w_acc) begin
         if (w_in_l) begin
            r_lock <= 1'b0;
            r_ptr  <= (w_gidx == S'(M-1)) ? '0 : w_gidx + 1'b1;
         end else begin
            r_lock  <= 1'b1;
            r_lport <= w_gidx;
         end
      end
   end

   generate
      if (Q != 0) begin : g_skid
         logic [N-1:0] r_d0, r_d1;
         logic [S-1:0] r_s0, r_s1;
         logic         r_l0, r_l1;
         logic [1:0]   r_cnt;
         logic         w_full;
         logic         w_pop;

         assign w_full = (r_cnt == 2'd2);
         assign w_pop  = (r_cnt != 2'd0) & arb.i_z_r;
         // Ready looks only at skid occupancy, never at i_z_r; the second
         // entry absorbs the beat accepted in the cycle downstream stalls.
         assign w_rdy  = w_grant & {M{~w_full}};

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_cnt <= '0;
               r_d0  <= '0;
               r_s0  <= '0;
               r_l0  <= 1'b0;
               r_d1  <= '0;
               r_s1  <= '0;
               r_l1  <= 1'b0;
            end else begin
               case ({w_acc, w_pop})
                  2'b10: begin
                     if (r_cnt == 2'd0) begin
                        r_d0 <= w_in_d;
                        r_s0 <= w_gidx;
                        r_l0 <= w_in_l;
                     end else begin
                        r_d1 <= w_in_d;
                        r_s1 <= w_gidx;
                        r_l1 <= w_in_l;
                     end
                     r_cnt <= r_cnt + 2'd1;
                  end
                  2'b01: begin
                     r_d0  <= r_d1;
                     r_s0  <= r_s1;
                     r_l0  <= r_l1;
                     r_cnt <= r_cnt - 2'd1;
                  end
                  2'b11: begin
                     // Only reachable with one entry: the new beat becomes
                     // the head as the old head leaves.
                     r_d0 <= w_in_d;
                     r_s0 <= w_gidx;
                     r_l0 <= w_in_l;
                  end
                  default: ;
               endcase
            end
         end

         assign arb.o_z_v = (r_cnt != 2'd0);
         assign arb.o_z_d = r_d0;
         assign arb.o_z_s = r_s0;
         assign arb.o_z_l = r_l0;
      end else begin : g_comb
         assign w_rdy     = w_grant & {M{arb.i_z_r}};
         assign arb.o_z_v = w_gv;
         assign arb.o_z_d = w_gv ? w_in_d : '0;
         assign arb.o_z_s = w_gv ? w_gidx : '0;
         assign arb.o_z_l = w_gv & w_in_l;
      end
   endgenerate

`ifdef CORY_ARBN_WDOG_EN
   localparam int c_WCNT_W = (WDOG > 0) ? $clog2(WDOG + 1) : 1;

   logic [c_WCNT_W-1:0] r_wcnt [M];
   logic [M-1:0]        r_wdog;

   // A port waits while it is valid and not ready; the flag rises on the
   // stalled cycle that brings the counter to WDOG and holds until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wdog <= '0;
         for (int k = 0; k < M; k++)
            r_wcnt[k] <= '0;
      end else begin
         for (int k = 0; k < M; k++) begin
            if (!arb.i_a_v[k] || w_rdy[k]) begin
               r_wcnt[k] <= '0;
            end else if (r_wcnt[k] != c_WCNT_W'(WDOG)) begin
               r_wcnt[k] <= r_wcnt[k] + 1'b1;
               if (r_wcnt[k] == c_WCNT_W'(WDOG - 1))
                  r_wdog[k] <= 1'b1;
            end
         end
      end
   end

   assign arb.o_wdog = r_wdog;
`endif
endmodule
`default_nettype wire

// File: tb/tb_cory_arbn.sv
`default_nettype none
// ============================================================================
// Module   : tb_cory_arbn
// Purpose  : Directed self-checking bench for cory_arbn. Two instances:
//            u_rr (M=5, round-robin, skid output, WDOG=8) and
//            u_fp (M=4, fixed priority, combinational output).
//            Port k of u_rr sends data {k, beat#}; port k of u_fp sends
//            {k, 4'h5}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cory_arbn;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cory_arbn_if #(.M(5), .N(8)) rr_if ();
   cory_arbn_if #(.M(4), .N(8)) fp_if ();

   cory_arbn #(.M(5), .N(8), .ROUND(1), .Q(1), .WDOG(8)) u_rr (
      .clk   (clk),
      .reset (reset),
      .arb   (rr_if.slave)
   );

   cory_arbn #(.M(4), .N(8), .ROUND(0), .Q(0), .WDOG(8)) u_fp (
      .clk   (clk),
      .reset (reset),
      .arb   (fp_if.slave)
   );

   logic [4:0] rr_seq [5];
   int n_cmp = 0;
   int n_err = 0;

   for (genvar k = 0; k < 5; k++) begin : g_rr_data
      assign rr_if.i_a_d[k*8 +: 8] = {3'(k), rr_seq[k]};
   end
   for (genvar k = 0; k < 4; k++) begin : g_fp_data
      assign fp_if.i_a_d[k*8 +: 8] = {4'(k), 4'h5};
   end

   // Backpressure vectors for u_rr, ports 0..2 valid with single beats.
   localparam logic       BP_ZR [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   localparam logic [4:0] BP_AR [9] = '{5'b00001, 5'b00010, 5'b00000, 5'b00000, 5'b00100,
                                        5'b00001, 5'b00000, 5'b00010, 5'b00100};
   localparam logic       BP_OV [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam logic [7:0] BP_D  [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h40, 8'h40, 8'h01, 8'h21};
   localparam logic [2:0] BP_S  [9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd0, 3'd1};

   // Lock vectors: port 4 sends a 3-beat packet with a bubble, ports 0/1 wait.
   localparam logic [4:0] LK_V  [7] = '{5'b10000, 5'b10011, 5'b00011, 5'b10011, 5'b00011, 5'b00011, 5'b00011};
   localparam logic [4:0] LK_L  [7] = '{5'b00000, 5'b00011, 5'b00011, 5'b10011, 5'b00011, 5'b00011, 5'b00011};
   localparam logic [4:0] LK_AR [7] = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b00001, 5'b00010, 5'b00001};
   localparam logic       LK_OV [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   localparam logic [7:0] LK_D  [7] = '{8'h00, 8'h80, 8'h81, 8'h00, 8'h82, 8'h00, 8'h20};
   localparam logic [2:0] LK_S  [7] = '{3'd0, 3'd4, 3'd4, 3'd0, 3'd4, 3'd0, 3'd1};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic rr_expect(input string tag, input logic [4:0] ar, input logic ov,
                            input logic [7:0] d, input logic [2:0] s);
      check({tag, "_ar"}, 32'(rr_if.o_a_r), 32'(ar));
      check({tag, "_ov"}, 32'(rr_if.o_z_v), 32'(ov));
      if (ov) begin
         check({tag, "_d"}, 32'(rr_if.o_z_d), 32'(d));
         check({tag, "_s"}, 32'(rr_if.o_z_s), 32'(s));
      end
   endtask

   task automatic fp_expect(input string tag, input logic [3:0] ar, input logic ov,
                            input logic [7:0] d, input logic [1:0] s, input logic l);
      check({tag, "_ar"}, 32'(fp_if.o_a_r), 32'(ar));
      check({tag, "_ov"}, 32'(fp_if.o_z_v), 32'(ov));
      check({tag, "_d"},  32'(fp_if.o_z_d), 32'(d));
      check({tag, "_s"},  32'(fp_if.o_z_s), 32'(s));
      check({tag, "_l"},  32'(fp_if.o_z_l), 32'(l));
   endtask

   // Advance one clock; a u_rr sender moves to its next beat once accepted.
   task automatic tick();
      logic [4:0] acc;
      acc = rr_if.i_a_v & rr_if.o_a_r;
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++)
         if (acc[k]) rr_seq[k] = rr_seq[k] + 5'd1;
   endtask

   task automatic idle_inputs();
      rr_if.i_a_v = '0;
      rr_if.i_a_l = '0;
      rr_if.i_z_r = 1'b1;
      fp_if.i_a_v = '0;
      fp_if.i_a_l = '0;
      fp_if.i_z_r = 1'b1;
      for (int k = 0; k < 5; k++) rr_seq[k] = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic rr_drive(input logic [4:0] v, input logic [4:0] l, input logic zr);
      rr_if.i_a_v = v;
      rr_if.i_a_l = l;
      rr_if.i_z_r = zr;
      #1;
   endtask

   task automatic fp_drive(input logic [3:0] v, input logic [3:0] l, input logic zr);
      fp_if.i_a_v = v;
      fp_if.i_a_l = l;
      fp_if.i_z_r = zr;
      #1;
   endtask

   initial begin
      idle_inputs();
      #1 reset = 1'b1;
      #7;
      // Reset state
      rr_expect("rst_rr", 5'b00000, 1'b0, 8'h00, 3'd0);
      check("rst_rr_d", 32'(rr_if.o_z_d), 32'h0);
      fp_expect("rst_fp", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);

      // Round-robin, all five ports single-beat, downstream always ready
      do_reset();
      rr_drive(5'b11111, 5'b11111, 1'b1);
      for (int i = 0; i < 8; i++) begin
         int b;
         b = (i == 0) ? 0 : i - 1;
         rr_expect($sformatf("rr%0d", i), 5'b00001 << (i % 5), (i != 0),
                   {3'(b % 5), 5'(b / 5)}, 3'(b % 5));
         tick();
      end

      // Downstream backpressure through the skid
      do_reset();
      for (int i = 0; i < 9; i++) begin
         rr_drive(5'b00111, 5'b11111, BP_ZR[i]);
         rr_expect($sformatf("bp%0d", i), BP_AR[i], BP_OV[i], BP_D[i], BP_S[i]);
         tick();
      end

      // Packet lock, bubble while locked, pointer wrap 4 -> 0
      do_reset();
      for (int i = 0; i < 7; i++) begin
         rr_drive(LK_V[i], LK_L[i], 1'b1);
         rr_expect($sformatf("lk%0d", i), LK_AR[i], LK_OV[i], LK_D[i], LK_S[i]);
         tick();
      end

      // Asynchronous reset mid-packet with two beats buffered
      do_reset();
      rr_drive(5'b01000, 5'b00000, 1'b0);
      rr_expect("mr0", 5'b01000, 1'b0, 8'h00, 3'd0);
      tick();
      rr_expect("mr1", 5'b01000, 1'b1, 8'h60, 3'd3);
      tick();
      rr_drive(5'b01001, 5'b00001, 1'b0);
      rr_expect("mr2", 5'b00000, 1'b1, 8'h60, 3'd3);
      reset = 1'b1;
      #1;
      rr_expect("mr_rst", 5'b00001, 1'b0, 8'h00, 3'd0);
      check("mr_rst_d", 32'(rr_if.o_z_d), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      rr_drive(5'b01001, 5'b00001, 1'b1);
      rr_expect("mr3", 5'b00001, 1'b0, 8'h00, 3'd0);
      tick();
      rr_expect("mr4", 5'b01000, 1'b1, 8'h00, 3'd0);
      tick();
      rr_drive(5'b00000, 5'b00000, 1'b1);

      // Fixed priority, combinational output
      do_reset();
      fp_drive(4'b0000, 4'b1111, 1'b1);
      fp_expect("fp0", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
      fp_drive(4'b1010, 4'b1111, 1'b1);
      fp_expect("fp1", 4'b0010, 1'b1, 8'h15, 2'd1, 1'b1);
      tick();
      fp_expect("fp2", 4'b0010, 1'b1, 8'h15, 2'd1, 1'b1);
      tick();
      fp_drive(4'b1010, 4'b1111, 1'b0);
      fp_expect("fp3", 4'b0000, 1'b1, 8'h15, 2'd1, 1'b1);
      fp_drive(4'b1000, 4'b1111, 1'b1);
      fp_expect("fp4", 4'b1000, 1'b1, 8'h35, 2'd3, 1'b1);
      fp_drive(4'b1000, 4'b0000, 1'b1);
      fp_expect("fp5", 4'b1000, 1'b1, 8'h35, 2'd3, 1'b0);
      tick();
      fp_drive(4'b1010, 4'b0000, 1'b1);
      fp_expect("fp6", 4'b1000, 1'b1, 8'h35, 2'd3, 1'b0);
      tick();
      fp_drive(4'b1010, 4'b1000, 1'b1);
      fp_expect("fp7", 4'b1000, 1'b1, 8'h35, 2'd3, 1'b1);
      tick();
      fp_drive(4'b1010, 4'b1010, 1'b1);
      fp_expect("fp8", 4'b0010, 1'b1, 8'h15, 2'd1, 1'b1);
      tick();
      fp_drive(4'b0000, 4'b0000, 1'b1);

`ifdef CORY_ARBN_WDOG_EN
      // Port 1 starved by a long port-0 packet
      do_reset();
      rr_drive(5'b00001, 5'b00000, 1'b1);
      tick();
      for (int i = 1; i <= 8; i++) begin
         rr_drive(5'b00011, 5'b00000, 1'b1);
         check($sformatf("wd%0d", i), 32'(rr_if.o_wdog), 32'h0);
         tick();
      end
      check("wd_set", 32'(rr_if.o_wdog), 32'h2);
      rr_drive(5'b00011, 5'b00001, 1'b1);
      tick();
      rr_drive(5'b00010, 5'b00010, 1'b1);
      check("wd_srv_ar", 32'(rr_if.o_a_r), 32'h2);
      tick();
      rr_drive(5'b00000, 5'b00000, 1'b1);
      check("wd_hold", 32'(rr_if.o_wdog), 32'h2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
